// File: rtl/cci_mpf_prim_arb_pkg.sv
// Shared types and helpers for the CCI-P packet-atomic round-robin arbiter.
package cci_mpf_prim_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } t_arb_state;

  // Encoded cl_len to beat count.
  function automatic logic [2:0] arb_beats(input logic [1:0] len);
    return {1'b0, len} + 3'd1;
  endfunction

endpackage

// File: rtl/cci_mpf_prim_arb_pkt_rr_if.sv
// Request/grant bundle between the per-port request buffers and the arbiter.
interface cci_mpf_prim_arb_pkt_rr_if
  import cci_mpf_prim_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = $clog2(N_PORTS)
);

  // Handshake: req[p] is the valid of port p's buffer head; grant[p] is the
  // matching ready. A beat moves (and the buffer dequeues) in any cycle where
  // both are high. Grant never depends on anything but the current inputs and
  // registered state, and req must not depend on grant.
  logic [N_PORTS-1:0]      req;
  logic [N_PORTS-1:0]      sop;
  logic [N_PORTS-1:0][1:0] len;
  logic                    alm_full;

  logic [N_PORTS-1:0]      grant;
  logic                    grant_valid;
  logic [IDX_W-1:0]        grant_idx;
  logic                    pkt_active;
  logic                    proto_err;
  t_arb_state              state;

  modport master (
    output req, sop, len, alm_full,
    input  grant, grant_valid, grant_idx, pkt_active, proto_err, state
  );

  modport slave (
    input  req, sop, len, alm_full,
    output grant, grant_valid, grant_idx, pkt_active, proto_err, state
  );

endinterface

// File: rtl/cci_mpf_prim_rr_pick.sv
// Rotating-priority picker: first requester strictly after last_winner_i, with wrap.
module cci_mpf_prim_rr_pick #(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]   last_winner_i,
  output logic [N_PORTS-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [2*N_PORTS-1:0] dbl;
  logic [2*N_PORTS-1:0] mask;
  logic [2*N_PORTS-1:0] masked;
  logic [N_PORTS-1:0]   one;

  // The doubled vector turns wrap-around into a plain lowest-bit search over
  // the window last_winner+1 .. last_winner+N_PORTS.
  always_comb begin
    one    = '0;
    one[0] = 1'b1;
    dbl    = {req_i, req_i};
    mask   = '0;
    for (int k = 0; k < 2*N_PORTS; k++) begin
      mask[k] = (k > int'(last_winner_i)) && (k <= int'(last_winner_i) + N_PORTS);
    end
    masked  = dbl & mask;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 2*N_PORTS-1; k >= 0; k--) begin
      if (masked[k]) begin
        any_o = 1'b1;
        idx_o = (k >= N_PORTS) ? IDX_W'(k - N_PORTS) : IDX_W'(k);
      end
    end
    grant_o = any_o ? (one << idx_o) : '0;
  end

endmodule

// File: rtl/cci_mpf_prim_arb_pkt_rr.sv
// N-way round-robin arbiter for one CCI-P request channel; multi-beat packets
// hold the channel until their last beat is granted.
module cci_mpf_prim_arb_pkt_rr
  import cci_mpf_prim_arb_pkg::*;
#(
  parameter int N_PORTS            = 4,
  parameter int MAX_BEATS          = 4,
  parameter bit FATAL_ON_PROTO_ERR = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  cci_mpf_prim_arb_pkt_rr_if.slave    arb
);

  localparam int IDX_W = $clog2(N_PORTS);
  localparam int BL_W  = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;

  t_arb_state         state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   last_q;
  logic [BL_W-1:0]    left_q;
  logic               err_q;

  logic [N_PORTS-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic               win_sop;
  logic [1:0]         win_len;
  logic               proto_now;
  logic [N_PORTS-1:0] one;

  cci_mpf_prim_rr_pick #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i         (arb.req),
    .last_winner_i (last_q),
    .grant_o       (pick_oh),
    .idx_o         (pick_idx),
    .any_o         (pick_any)
  );

  // While locked only the owner is eligible and alm_full is ignored, so the
  // tail of a packet always drains into downstream buffering.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = last_q;
    if (!reset) begin
      if (state_q == LOCKED) begin
        if (arb.req[owner_q]) begin
          win_valid = 1'b1;
          win_idx   = owner_q;
        end
      end else if (!arb.alm_full && pick_any) begin
        win_valid = 1'b1;
        win_idx   = pick_idx;
      end
    end
    win_sop = arb.sop[win_idx];
    win_len = arb.len[win_idx];
    one     = '0;
    one[0]  = 1'b1;
  end

  always_comb begin
    proto_now = 1'b0;
    if (win_valid) begin
      if (state_q == LOCKED) begin
        proto_now = win_sop;
      end else begin
        proto_now = !win_sop || (32'(arb_beats(win_len)) > MAX_BEATS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      left_q  <= '0;
      last_q  <= IDX_W'(N_PORTS - 1);
      err_q   <= 1'b0;
    end else begin
      if (proto_now) err_q <= 1'b1;
      if (win_valid) begin
        case (state_q)
          IDLE: begin
            last_q <= win_idx;
            if (win_sop && (win_len != 2'd0)) begin
              state_q <= LOCKED;
              owner_q <= win_idx;
              left_q  <= BL_W'(win_len);
            end
          end
          LOCKED: begin
            left_q <= left_q - BL_W'(1);
            if (left_q == BL_W'(1)) begin
              state_q <= IDLE;
              last_q  <= owner_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (FATAL_ON_PROTO_ERR && !reset && proto_now) begin
      $fatal(1, "cci_mpf_prim_arb_pkt_rr: protocol violation on port %0d", win_idx);
    end
  end

  assign arb.grant       = win_valid ? (one << win_idx) : '0;
  assign arb.grant_valid = win_valid;
  assign arb.grant_idx   = win_idx;
  assign arb.pkt_active  = (state_q == LOCKED);
  assign arb.proto_err   = err_q;
  assign arb.state       = state_q;

endmodule

// File: tb/tb_cci_mpf_prim_arb_pkt_rr.sv
// Scoreboard bench for cci_mpf_prim_arb_pkt_rr: directed scenarios plus random traffic.
module tb_cci_mpf_prim_arb_pkt_rr;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int IW = 2;
  localparam int W  = N + IW + 2;

  logic clk;
  logic reset;

  cci_mpf_prim_arb_pkt_rr_if #(.N_PORTS(N)) bus ();

  cci_mpf_prim_arb_pkt_rr #(
    .N_PORTS            (N),
    .MAX_BEATS          (MB),
    .FATAL_ON_PROTO_ERR (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // reference model state
  int m_last;
  bit m_lock;
  int m_owner;
  int m_left;
  bit m_err;

  task automatic model_reset();
    m_last  = N - 1;
    m_lock  = 1'b0;
    m_owner = 0;
    m_left  = 0;
    m_err   = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0][1:0] mklen(input int port, input int l);
    logic [N-1:0][1:0] v;
    v = '0;
    v[port] = 2'(l);
    return v;
  endfunction

  // driver: apply one cycle of inputs, push expected outputs, advance model
  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] s,
                       input logic [N-1:0][1:0] l, input logic af, input logic rst);
    logic [N-1:0]    g;
    logic [W-1:0]    e;
    logic [31:0]     idx;
    int              win;
    g   = '0;
    win = -1;
    idx = 32'(m_last);
    if (!rst) begin
      if (m_lock) begin
        if (r[m_owner]) win = m_owner;
      end else if (!af) begin
        for (int k = 1; k <= N; k++) begin
          if (win < 0 && r[(m_last + k) % N]) win = (m_last + k) % N;
        end
      end
    end
    if (win >= 0) begin
      g[win] = 1'b1;
      idx    = 32'(win);
    end
    e = {g, idx[IW-1:0], m_lock, m_err};
    exp_q.push_back(e);
    bus.req      = r;
    bus.sop      = s;
    bus.len      = l;
    bus.alm_full = af;
    reset        = rst;
    if (rst) begin
      model_reset();
    end else if (win >= 0) begin
      if (m_lock) begin
        if (s[win]) m_err = 1'b1;
        m_left--;
        if (m_left == 0) begin
          m_lock = 1'b0;
          m_last = m_owner;
        end
      end else begin
        m_last = win;
        if (!s[win] || (int'(l[win]) + 1 > MB)) m_err = 1'b1;
        if (s[win] && l[win] != 2'd0) begin
          m_lock  = 1'b1;
          m_owner = win;
          m_left  = int'(l[win]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: compare every presented output cycle against the scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("grant",       32'(bus.grant),       32'(e[W-1 -: N]));
      check("grant_valid", 32'(bus.grant_valid), 32'(|e[W-1 -: N]));
      check("grant_idx",   32'(bus.grant_idx),   32'(e[IW+1:2]));
      check("pkt_active",  32'(bus.pkt_active),  32'(e[1]));
      check("proto_err",   32'(bus.proto_err),   32'(e[0]));
    end
  end

  initial begin
    logic [N-1:0]      r;
    logic [N-1:0]      s;
    logic [N-1:0][1:0] l;
    bus.req      = '0;
    bus.sop      = '0;
    bus.len      = '0;
    bus.alm_full = 1'b0;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    drive('0, '0, '0, 1'b0, 1'b1);

    // round-robin rotation, single-beat packets
    repeat (8) drive(4'hF, 4'hF, '0, 1'b0, 1'b0);

    // packet lock: port 1 four beats, then port 2
    drive('0, '0, '0, 1'b0, 1'b1);
    drive(4'b0001, 4'hF, '0, 1'b0, 1'b0);
    drive(4'hF, 4'hF, mklen(1, 3), 1'b0, 1'b0);
    repeat (3) drive(4'hF, 4'b1101, '0, 1'b0, 1'b0);
    drive(4'hF, 4'hF, '0, 1'b0, 1'b0);

    // almost-full gating
    repeat (2) drive(4'hF, 4'hF, '0, 1'b1, 1'b0);
    drive(4'b1000, 4'b1000, mklen(3, 1), 1'b0, 1'b0);
    drive(4'b1000, 4'b0000, '0, 1'b1, 1'b0);
    repeat (2) drive(4'hF, 4'hF, '0, 1'b1, 1'b0);

    // bubble inside a packet from port 0
    drive(4'b0001, 4'b0001, mklen(0, 3), 1'b0, 1'b0);
    drive(4'b0001, 4'b0000, '0, 1'b0, 1'b0);
    repeat (3) drive(4'hE, 4'hE, '0, 1'b0, 1'b0);
    repeat (2) drive(4'hF, 4'hE, '0, 1'b0, 1'b0);
    drive(4'hF, 4'hF, '0, 1'b0, 1'b0);

    // reset after 2 of 4 beats from port 2
    drive(4'b0100, 4'b0100, mklen(2, 3), 1'b0, 1'b0);
    drive(4'b0100, 4'b0000, '0, 1'b0, 1'b0);
    drive(4'hF, 4'hF, '0, 1'b0, 1'b1);
    drive(4'hF, 4'hF, '0, 1'b0, 1'b0);

    // protocol error: sop while locked, sticky until reset
    drive(4'b0010, 4'b0010, mklen(1, 2), 1'b0, 1'b0);
    drive(4'b0010, 4'b0010, '0, 1'b0, 1'b0);
    drive(4'b0010, 4'b0000, '0, 1'b0, 1'b0);
    repeat (2) drive(4'hF, 4'hF, '0, 1'b0, 1'b0);
    drive('0, '0, '0, 1'b0, 1'b1);
    drive(4'hF, 4'hF, '0, 1'b0, 1'b0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++) begin
        r[p] = ($urandom_range(0, 9) < 6);
        s[p] = ($urandom_range(0, 19) != 0);
        l[p] = 2'($urandom_range(0, 3));
      end
      if (m_lock) s[m_owner] = ($urandom_range(0, 19) == 0);
      drive(r, s, l, ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
    end

    drive('0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
